// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_size_e   : access size encoding carried on req_size (BYTE/HALF/WORD/DWORD)
//   lsu_state_e  : LSU sequencer states; LSU_BUS2 exists only when
//                  LSU_MISALIGN_SPLIT_EN is defined
//   FUNCT3_*     : load/store funct3 encodings used by the decoder
//   size_bytes / align_mask : helpers turning a size into a byte count and
//                  the low-address mask that must be zero for natural alignment
package riscv_lsu_pkg;

   typedef enum logic [1:0] {
      MEM_SIZE_BYTE  = 2'b00,
      MEM_SIZE_HALF  = 2'b01,
      MEM_SIZE_WORD  = 2'b10,
      MEM_SIZE_DWORD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUS  = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
      LSU_BUS2 = 2'd2,
`endif
      LSU_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LD  = 3'b011;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_LWU = 3'b110;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;
   localparam logic [2:0] FUNCT3_SD  = 3'b011;

   function automatic int size_bytes(input mem_size_e size);
      return 1 << size;
   endfunction

   function automatic logic [2:0] align_mask(input mem_size_e size);
      return 3'(size_bytes(size) - 1);
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   st_size, st_offset, st_misaligned, st_wdata : store request (offset is the
//       byte position inside the bus word)
//   st_wdata_wide, st_be_wide : store data / byte enables laid out over two
//       consecutive bus words; the low half is the first beat
//   ld_size, ld_offset, ld_unsigned, ld_data_wide : load request and the raw
//       bus data (second beat in the upper half, zero when single beat)
//   ld_result : extracted, sign/zero-extended load value
module riscv_lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int NB = XLEN / 8,
   localparam int OW = $clog2(NB)
) (
   input  mem_size_e             st_size,
   input  logic [OW-1:0]         st_offset,
   input  logic                  st_misaligned,
   input  logic [XLEN-1:0]       st_wdata,
   output logic [2*XLEN-1:0]     st_wdata_wide,
   output logic [2*NB-1:0]       st_be_wide,
   input  mem_size_e             ld_size,
   input  logic [OW-1:0]         ld_offset,
   input  logic                  ld_unsigned,
   input  logic [2*XLEN-1:0]     ld_data_wide,
   output logic [XLEN-1:0]       ld_result
);

   logic [XLEN-1:0] st_mask;
   logic [XLEN-1:0] st_lane;
   logic [XLEN-1:0] st_repl;
   logic [XLEN-1:0] ld_mask;
   logic [XLEN-1:0] ld_shifted;
   logic            ld_msb;

   function automatic logic [XLEN-1:0] data_mask(input mem_size_e size);
      case (size)
         MEM_SIZE_BYTE: return XLEN'(8'hFF);
         MEM_SIZE_HALF: return XLEN'(16'hFFFF);
         MEM_SIZE_WORD: return XLEN'(32'hFFFF_FFFF);
         default:       return '1;
      endcase
   endfunction

   // Aligned stores replicate the lane so any slave lane sees the data;
   // misaligned (split-capable) stores need the true shifted layout instead.
   always_comb begin
      st_mask = data_mask(st_size);
      st_lane = st_wdata & st_mask;
      case (st_size)
         MEM_SIZE_BYTE: st_repl = {NB{st_lane[7:0]}};
         MEM_SIZE_HALF: st_repl = {(NB/2){st_lane[15:0]}};
         MEM_SIZE_WORD: st_repl = {(NB/4){st_lane[31:0]}};
         default:       st_repl = st_lane;
      endcase
      st_be_wide = (2*NB)'((1 << size_bytes(st_size)) - 1) << st_offset;
      if (st_misaligned)
         st_wdata_wide = {{XLEN{1'b0}}, st_lane} << {st_offset, 3'b000};
      else
         st_wdata_wide = {{XLEN{1'b0}}, st_repl};
   end

   // Loads: bring the addressed byte to bit 0, then mask or sign-fill.
   always_comb begin
      ld_shifted = XLEN'(ld_data_wide >> {ld_offset, 3'b000});
      ld_mask    = data_mask(ld_size);
      case (ld_size)
         MEM_SIZE_BYTE: ld_msb = ld_shifted[7];
         MEM_SIZE_HALF: ld_msb = ld_shifted[15];
         MEM_SIZE_WORD: ld_msb = ld_shifted[31];
         default:       ld_msb = 1'b0;
      endcase
      if (!ld_unsigned && ld_msb)
         ld_result = ld_shifted | ~ld_mask;
      else
         ld_result = ld_shifted & ld_mask;
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit for the multi-cycle core's memory phase.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : one request from the core, taken when req_ready
//   rsp_*               : one-cycle completion pulse with load data / error
//   mem_*               : single-outstanding valid/ready data-memory port
// Parameters: XLEN (32 or 64), ADDR_W, TIMEOUT (0 disables the bus timeout).
// Optional feature macro LSU_MISALIGN_SPLIT_EN: serve misaligned accesses,
// using a second bus beat (state LSU_BUS2) when they cross a bus word.
// Without it any misaligned access completes with rsp_err and no bus beat.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic [4:0]          rsp_rd,
   output logic                rsp_err,
   output logic                mem_valid,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic                mem_ready,
   input  logic                mem_err,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   lsu_state_e         state, next_state;
   mem_size_e          req_size_e, cap_size;
   logic               cap_unsigned;
   logic [OW-1:0]      cap_offset;
   logic               accept, req_illegal, req_misaligned, req_err;
   logic [CW-1:0]      tmo_cnt;
   logic               timeout_hit;
   logic [2*XLEN-1:0]  st_wdata_wide, ld_data_wide;
   logic [2*NB-1:0]    st_be_wide;
   logic [XLEN-1:0]    ld_result;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic               req_cross, split_q;
   logic [XLEN-1:0]    beat1_q, wdata2_q;
   logic [NB-1:0]      be2_q;
`else
   logic               unused_upper;
`endif

   assign req_size_e     = mem_size_e'(req_size);
   assign accept         = req_valid && req_ready;
   assign req_illegal    = (XLEN == 32) && (req_size_e == MEM_SIZE_DWORD);
   assign req_misaligned = |(req_addr[2:0] & align_mask(req_size_e));
   assign timeout_hit    = (TIMEOUT > 0) && mem_valid && !mem_ready &&
                           (tmo_cnt == CW'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_SPLIT_EN
   assign req_cross    = (int'(req_addr[OW-1:0]) + size_bytes(req_size_e)) > NB;
   assign req_err      = req_illegal;
   // Second beat of a crossing load sits above the first so one shift merges them.
   assign ld_data_wide = (state == LSU_BUS2) ? {mem_rdata, beat1_q}
                                             : {{XLEN{1'b0}}, mem_rdata};
`else
   assign req_err      = req_illegal || req_misaligned;
   assign ld_data_wide = {{XLEN{1'b0}}, mem_rdata};
   assign unused_upper = ^{st_wdata_wide[2*XLEN-1:XLEN], st_be_wide[2*NB-1:NB]};
`endif

   riscv_lsu_align #(.XLEN(XLEN)) u_align (
      .st_size       (req_size_e),
      .st_offset     (req_addr[OW-1:0]),
      .st_misaligned (req_misaligned),
      .st_wdata      (req_wdata),
      .st_wdata_wide (st_wdata_wide),
      .st_be_wide    (st_be_wide),
      .ld_size       (cap_size),
      .ld_offset     (cap_offset),
      .ld_unsigned   (cap_unsigned),
      .ld_data_wide  (ld_data_wide),
      .ld_result     (ld_result)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= LSU_IDLE;
      else     state <= next_state;
   end

   // Next-state logic; requests with an error known up front skip the bus.
   always_comb begin
      next_state = state;
      case (state)
         LSU_IDLE: if (req_valid) next_state = req_err ? LSU_RESP : LSU_BUS;
         LSU_BUS: begin
            if (timeout_hit) next_state = LSU_RESP;
            else if (mem_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
               if (!mem_err && split_q) next_state = LSU_BUS2;
               else
`endif
               next_state = LSU_RESP;
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         LSU_BUS2: if (timeout_hit || mem_ready) next_state = LSU_RESP;
`endif
         LSU_RESP: next_state = LSU_IDLE;
         default:  next_state = LSU_IDLE;
      endcase
   end

   // State-decoded handshake outputs
   always_comb begin
      req_ready = 1'b0;
      mem_valid = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         LSU_IDLE: req_ready = 1'b1;
         LSU_BUS:  mem_valid = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
         LSU_BUS2: mem_valid = 1'b1;
`endif
         LSU_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Timeout counter restarts on every state change, so each beat gets a full budget.
   always_ff @(posedge clk) begin
      if (rst || (state != next_state)) tmo_cnt <= '0;
      else if (mem_valid && !mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Request capture, bus-beat registers and response data
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_size     <= MEM_SIZE_BYTE;
         cap_unsigned <= 1'b0;
         cap_offset   <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         rsp_rd       <= '0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_q      <= 1'b0;
         beat1_q      <= '0;
         wdata2_q     <= '0;
         be2_q        <= '0;
`endif
      end else begin
         case (state)
            LSU_IDLE: begin
               if (accept) begin
                  cap_size     <= req_size_e;
                  cap_unsigned <= req_unsigned;
                  cap_offset   <= req_addr[OW-1:0];
                  rsp_rd       <= req_rd;
                  mem_we       <= req_we;
                  mem_addr     <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                  mem_be       <= req_we ? st_be_wide[NB-1:0] : '1;
                  mem_wdata    <= req_we ? st_wdata_wide[XLEN-1:0] : '0;
                  rsp_err      <= req_err;
                  rsp_rdata    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                  split_q      <= req_cross && !req_err;
                  be2_q        <= req_we ? st_be_wide[2*NB-1:NB] : '1;
                  wdata2_q     <= req_we ? st_wdata_wide[2*XLEN-1:XLEN] : '0;
`endif
               end
            end
            LSU_BUS: begin
               if (timeout_hit) rsp_err <= 1'b1;
               else if (mem_ready) begin
                  if (mem_err) rsp_err <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                  else if (split_q) begin
                     beat1_q   <= mem_rdata;
                     mem_addr  <= mem_addr + ADDR_W'(NB);
                     mem_be    <= be2_q;
                     mem_wdata <= wdata2_q;
                  end
`endif
                  else if (!mem_we) rsp_rdata <= ld_result;
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            LSU_BUS2: begin
               if (timeout_hit) rsp_err <= 1'b1;
               else if (mem_ready) begin
                  if (mem_err) rsp_err <= 1'b1;
                  else if (!mem_we) rsp_rdata <= ld_result;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit for the multi-cycle RISC-V core, serving the STATE_MEMORY phase. Accepts one load/store request from the core, performs byte-lane alignment, write-strobe generation and load sign/zero extension, and drives a single-outstanding valid/ready data-memory port. Generalises the fixed 32-bit byte/half/word access to XLEN 32 or 64 (adds doubleword). Adds misalignment detection, a bus timeout and optional split misaligned access.

## Interface
- XLEN, 32: data width; 32 or 64 only.
- ADDR_W, 32: address width.
- TIMEOUT, 0: bus timeout in cycles; 0 disables timeout.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  request offered by core.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  mem_size_e: BYTE, HALF, WORD, DWORD (2'b11).
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- req_rd  in  5  destination register tag, returned unchanged.
- rsp_valid  out  1  one-cycle completion pulse; no back-pressure.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_rd  out  5  tag of completing request.
- rsp_err  out  1  misaligned, illegal size, bus error or timeout.
- mem_valid, mem_we  out  1  bus request / direction.
- mem_addr  out  ADDR_W  XLEN/8-aligned address.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_be  out  XLEN/8  byte enables (stores); all ones for loads.
- mem_ready, mem_err  in  1  beat accept / beat error, sampled together.
- mem_rdata  in  XLEN  valid in the mem_ready cycle.

## Operation
- States lsu_state_e: IDLE, BUS, BUS2 (macro only), RESP.
- IDLE: req_valid && req_ready captures all req_* fields. Illegal size (DWORD with XLEN=32) or misaligned (addr not multiple of size) -> RESP with err, no bus beat. Otherwise -> BUS.
- BUS: mem_valid high; addr/we/wdata/be stable until mem_ready. mem_ready && !mem_err -> RESP (or BUS2 if split). mem_ready && mem_err -> RESP with err.
- Load extract: shift mem_rdata right by 8*offset, mask to size, sign-extend from size MSB unless req_unsigned. DWORD ignores req_unsigned.
- Store: mem_wdata = size-lane of req_wdata replicated across bus; mem_be = size mask << offset.
- RESP: rsp_valid=1 for exactly one cycle, -> IDLE.
- Timeout (TIMEOUT>0): counter clears on entry to BUS/BUS2, increments each cycle mem_valid && !mem_ready; on reaching TIMEOUT, mem_valid drops, -> RESP with err. Late mem_ready afterwards ignored.

## Timing
- Reset values: mem_valid 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, rsp_rd 0, mem_addr 0, mem_be 0, mem_wdata 0, mem_we 0; state IDLE so req_ready=1 from first cycle after reset; req_valid ignored while rst high.
- Aligned access, zero-wait bus: accept cycle T, mem_valid T+1, rsp_valid T+2. Each wait state adds one cycle.
- Error without bus: accept T, rsp_valid T+1.
- Reset mid-transaction: next edge forces IDLE and all reset values; in-flight beat abandoned, no rsp_valid.
- Back-to-back: new request accepted the cycle after rsp_valid.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned access within one bus word served in one beat; access crossing a bus word issues beat 1 at aligned addr (BUS) then beat 2 at addr+XLEN/8 (BUS2), merged before extension. Stores split be/wdata per beat. Error on beat 1 aborts beat 2. Latency +1 beat.
- Undefined: any misaligned access returns rsp_err with no bus beat; BUS2 absent.

## Structure
- riscv_pkg: add MEM_SIZE_DWORD=2'b11, lsu_state_e, FUNCT3_LWU=3'b110, FUNCT3_LD/SD=3'b011.
- Sub-module riscv_lsu_align: combinational lane shift, be/wdata generation, load extension; parametrised by XLEN.

## Test plan
- XLEN=32, LH at 0x102, mem_rdata 0x8001_0000 -> mem_addr 0x100, rsp_rdata 0xFFFF_8001; LHU -> 0x0000_8001.
- SB 0xAB at 0x203 -> mem_addr 0x200, mem_be 4'b1000, mem_wdata 0xABAB_ABAB, rsp_valid with rsp_rdata 0.
- LW at 0x102, macro off -> rsp_err=1 at T+1, mem_valid never high; macro on, beats 0x100 (0x4433_2211) and 0x104 (0x8877_6655) -> rsp_rdata 0x6655_4433.
- TIMEOUT=8, mem_ready held 0 -> mem_valid high 8 cycles then low, rsp_valid+rsp_err next cycle.
- XLEN=64, LD at 0x1008, rdata 0x8000_0000_0000_0001 -> rsp_rdata unchanged; XLEN=32 DWORD -> rsp_err.
- rst asserted during 3-cycle wait state -> mem_valid 0 next cycle, no rsp_valid, next request served normally.
